// File: rtl/ecc_scrub_pkg.sv
// Shared types for the multi-way ECC scrubber.
// scrub_state_e : scrubber FSM states.
// err_record_t  : captured error record. Its fields are sized for the widest supported
//                 configuration (256 ways, 2^32 rows); users keep only the low bits they need.
package ecc_scrub_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StRead,
        StCheck,
        StWrite,
        StAdvance
    } scrub_state_e;

    localparam int unsigned RecWayBits  = 8;
    localparam int unsigned RecAddrBits = 32;

    typedef struct packed {
        logic                   multi;
        logic [RecWayBits-1:0]  way;
        logic [RecAddrBits-1:0] add;
    } err_record_t;

endpackage

// File: rtl/ecc_scrub_err_log.sv
// Error bookkeeping for the scrubber: two saturating error counters plus a single
// captured error record that is held until acknowledged.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   log_i                 decoder flags below are valid for a scrub read this cycle
//   single_i, multi_i     decoder flags; multi takes priority when both are set
//   way_i, add_i          position of the scrub read being logged
//   ack_i                 clears the record; beats a capture in the same cycle
//   single_cnt_o, multi_cnt_o  saturating counts
//   err_valid_o, err_multi_o, err_way_o, err_add_o  captured record
module ecc_scrub_err_log
    import ecc_scrub_pkg::*;
#(
    parameter int unsigned WayWidth  = 2,
    parameter int unsigned AddrWidth = 11,
    parameter int unsigned CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 log_i,
    input  logic                 single_i,
    input  logic                 multi_i,
    input  logic [WayWidth-1:0]  way_i,
    input  logic [AddrWidth-1:0] add_i,
    input  logic                 ack_i,
    output logic [CntWidth-1:0]  single_cnt_o,
    output logic [CntWidth-1:0]  multi_cnt_o,
    output logic                 err_valid_o,
    output logic                 err_multi_o,
    output logic [WayWidth-1:0]  err_way_o,
    output logic [AddrWidth-1:0] err_add_o
);

    localparam logic [CntWidth-1:0] CntMax = '1;

    logic [CntWidth-1:0] single_cnt_q, single_cnt_d;
    logic [CntWidth-1:0] multi_cnt_q, multi_cnt_d;
    logic                err_valid_q, err_valid_d;
    err_record_t         rec_q, rec_d;

    logic is_multi, is_single;

    assign is_multi  = log_i & multi_i;
    assign is_single = log_i & single_i & ~multi_i;

    always_comb begin
        single_cnt_d = single_cnt_q;
        multi_cnt_d  = multi_cnt_q;
        err_valid_d  = err_valid_q;
        rec_d        = rec_q;

        if (is_multi && (multi_cnt_q != CntMax)) begin
            multi_cnt_d = multi_cnt_q + 1'b1;
        end
        if (is_single && (single_cnt_q != CntMax)) begin
            single_cnt_d = single_cnt_q + 1'b1;
        end

        // An ack in the same cycle as a new error wins: the new error is not recorded.
        if (ack_i) begin
            err_valid_d = 1'b0;
        end else if ((is_multi || is_single) && !err_valid_q) begin
            err_valid_d = 1'b1;
            rec_d.multi = is_multi;
            rec_d.way   = RecWayBits'(way_i);
            rec_d.add   = RecAddrBits'(add_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            single_cnt_q <= '0;
            multi_cnt_q  <= '0;
            err_valid_q  <= 1'b0;
            rec_q        <= '0;
        end else begin
            single_cnt_q <= single_cnt_d;
            multi_cnt_q  <= multi_cnt_d;
            err_valid_q  <= err_valid_d;
            rec_q        <= rec_d;
        end
    end

    // Upper record bits beyond the configured widths are intentionally dropped.
    logic unused_rec;
    assign unused_rec = ^rec_q;

    assign single_cnt_o = single_cnt_q;
    assign multi_cnt_o  = multi_cnt_q;
    assign err_valid_o  = err_valid_q;
    assign err_multi_o  = rec_q.multi;
    assign err_way_o    = rec_q.way[WayWidth-1:0];
    assign err_add_o    = rec_q.add[AddrWidth-1:0];

endmodule

// File: rtl/ecc_scrubber_multi_way.sv
// Background scrubber for NumWays ECC-protected SRAM banks of one kind. Every way is a
// combinational passthrough from interconnect to bank, except way way_q while the scrubber
// is reading it, checking it, or writing a corrected word back.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   enable_i, interval_i         scrub enable, idle cycles between scrub ops
//   correct_en_i                 write corrected word back on a single-bit error
//   intc_*                       per-way interconnect side
//   bank_*, single/multi_err_i   per-way ECC SRAM wrapper side
//   single_cnt_o, multi_cnt_o    saturating scrub-found error counts
//   err_*                        first captured error record, cleared by err_ack_i
//   sweep_done_o                 one-cycle pulse after the last row of the last way
module ecc_scrubber_multi_way
    import ecc_scrub_pkg::*;
#(
    parameter int unsigned NumWays       = 4,
    parameter int unsigned Width         = 128,
    parameter int unsigned BeWidth       = Width / 8,
    parameter int unsigned Depth         = 2048,
    parameter int unsigned IntervalWidth = 16,
    parameter int unsigned MaxStall      = 64,
    parameter int unsigned CntWidth      = 16,
    parameter int unsigned AddrWidth     = $clog2(Depth),
    parameter int unsigned WayWidth      = (NumWays > 1) ? $clog2(NumWays) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                enable_i,
    input  logic [IntervalWidth-1:0]            interval_i,
    input  logic                                correct_en_i,
    input  logic [NumWays-1:0]                  intc_req_i,
    output logic [NumWays-1:0]                  intc_gnt_o,
    input  logic [NumWays-1:0]                  intc_we_i,
    input  logic [NumWays-1:0][BeWidth-1:0]     intc_be_i,
    input  logic [NumWays-1:0][AddrWidth-1:0]   intc_add_i,
    input  logic [NumWays-1:0][Width-1:0]       intc_wdata_i,
    output logic [NumWays-1:0][Width-1:0]       intc_rdata_o,
    output logic [NumWays-1:0]                  intc_multi_err_o,
    output logic [NumWays-1:0]                  bank_req_o,
    input  logic [NumWays-1:0]                  bank_gnt_i,
    output logic [NumWays-1:0]                  bank_we_o,
    output logic [NumWays-1:0][BeWidth-1:0]     bank_be_o,
    output logic [NumWays-1:0][AddrWidth-1:0]   bank_add_o,
    output logic [NumWays-1:0][Width-1:0]       bank_wdata_o,
    input  logic [NumWays-1:0][Width-1:0]       bank_rdata_i,
    input  logic [NumWays-1:0]                  single_err_i,
    input  logic [NumWays-1:0]                  multi_err_i,
    output logic [CntWidth-1:0]                 single_cnt_o,
    output logic [CntWidth-1:0]                 multi_cnt_o,
    output logic                                err_valid_o,
    output logic                                err_multi_o,
    output logic [WayWidth-1:0]                 err_way_o,
    output logic [AddrWidth-1:0]                err_add_o,
    input  logic                                err_ack_i,
    output logic                                sweep_done_o
);

    localparam int unsigned StallWidth = (MaxStall > 0) ? $clog2(MaxStall + 1) : 1;
    localparam logic [AddrWidth-1:0]  LastAdd = AddrWidth'(Depth - 1);
    localparam logic [WayWidth-1:0]   LastWay = WayWidth'(NumWays - 1);

    scrub_state_e              state_q, state_d;
    logic [AddrWidth-1:0]      add_q, add_d;
    logic [WayWidth-1:0]       way_q, way_d;
    logic [IntervalWidth-1:0]  ival_q, ival_d;
    logic [StallWidth-1:0]     stall_q, stall_d;
    logic [Width-1:0]          wbuf_q, wbuf_d;
    logic                      sweep_q, sweep_d;

    logic forced;
    logic scrub_go;

    // After MaxStall blocked Read cycles the scrub read pre-empts the interconnect.
    assign forced   = (MaxStall != 0) && (stall_q == StallWidth'(MaxStall));
    assign scrub_go = (!intc_req_i[way_q] || forced) && bank_gnt_i[way_q];

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            add_q   <= '0;
            way_q   <= '0;
            ival_q  <= '0;
            stall_q <= '0;
            wbuf_q  <= '0;
            sweep_q <= 1'b0;
        end else begin
            state_q <= state_d;
            add_q   <= add_d;
            way_q   <= way_d;
            ival_q  <= ival_d;
            stall_q <= stall_d;
            wbuf_q  <= wbuf_d;
            sweep_q <= sweep_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        add_d   = add_q;
        way_d   = way_q;
        ival_d  = ival_q;
        stall_d = stall_q;
        wbuf_d  = wbuf_q;
        sweep_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable_i) begin
                    if (interval_i == '0) begin
                        state_d = StRead;
                    end else begin
                        ival_d  = interval_i;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                ival_d = ival_q - 1'b1;
                if (ival_q <= IntervalWidth'(1)) begin
                    ival_d  = '0;
                    state_d = StRead;
                end
            end
            StRead: begin
                if (scrub_go) begin
                    stall_d = '0;
                    state_d = StCheck;
                end else if ((MaxStall != 0) && !forced) begin
                    stall_d = stall_q + 1'b1;
                end
            end
            StCheck: begin
                if (single_err_i[way_q] && !multi_err_i[way_q] && correct_en_i) begin
                    wbuf_d  = bank_rdata_i[way_q];
                    state_d = StWrite;
                end else begin
                    state_d = StAdvance;
                end
            end
            StWrite: begin
                if (bank_gnt_i[way_q]) begin
                    state_d = StAdvance;
                end
            end
            StAdvance: begin
                // Way is the inner loop so each row is swept across all banks in turn.
                if (way_q == LastWay) begin
                    way_d = '0;
                    add_d = add_q + 1'b1;
                    if (add_q == LastAdd) begin
                        sweep_d = 1'b1;
                    end
                end else begin
                    way_d = way_q + 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic: passthrough everywhere, overridden only on way way_q.
    always_comb begin
        bank_req_o       = intc_req_i;
        bank_we_o        = intc_we_i;
        bank_be_o        = intc_be_i;
        bank_add_o       = intc_add_i;
        bank_wdata_o     = intc_wdata_i;
        intc_gnt_o       = bank_gnt_i;
        intc_rdata_o     = bank_rdata_i;
        intc_multi_err_o = multi_err_i;

        unique case (state_q)
            StRead: begin
                if (!intc_req_i[way_q] || forced) begin
                    bank_req_o[way_q]   = 1'b1;
                    bank_we_o[way_q]    = 1'b0;
                    bank_be_o[way_q]    = '0;
                    bank_add_o[way_q]   = add_q;
                    bank_wdata_o[way_q] = '0;
                    if (forced) begin
                        intc_gnt_o[way_q] = 1'b0;
                    end
                end
            end
            // The way stays locked from Check to the end of Write so a write-back cannot
            // interleave with interconnect traffic to the same row.
            StCheck: begin
                bank_req_o[way_q] = 1'b0;
                intc_gnt_o[way_q] = 1'b0;
            end
            StWrite: begin
                bank_req_o[way_q]   = 1'b1;
                bank_we_o[way_q]    = 1'b1;
                bank_be_o[way_q]    = '1;
                bank_add_o[way_q]   = add_q;
                bank_wdata_o[way_q] = wbuf_q;
                intc_gnt_o[way_q]   = 1'b0;
            end
            default: ;
        endcase
    end

    assign sweep_done_o = sweep_q;

    ecc_scrub_err_log #(
        .WayWidth  (WayWidth),
        .AddrWidth (AddrWidth),
        .CntWidth  (CntWidth)
    ) u_err_log (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .log_i        (state_q == StCheck),
        .single_i     (single_err_i[way_q]),
        .multi_i      (multi_err_i[way_q]),
        .way_i        (way_q),
        .add_i        (add_q),
        .ack_i        (err_ack_i),
        .single_cnt_o (single_cnt_o),
        .multi_cnt_o  (multi_cnt_o),
        .err_valid_o  (err_valid_o),
        .err_multi_o  (err_multi_o),
        .err_way_o    (err_way_o),
        .err_add_o    (err_add_o)
    );

endmodule

// File: tb/tb_ecc_scrubber_multi_way.sv
// Bench for ecc_scrubber_multi_way: 2 ways x 4 rows, 32-bit words, MaxStall 8, 4-bit counters.
// A behavioural bank model returns stored words and per-location error flags; scrub reads
// are checked against the expected sweep order (way inner, row outer).
module tb_ecc_scrubber_multi_way;

    localparam int NW = 2;
    localparam int D  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_i, enable, correct_en, err_ack;
    logic [3:0]           interval;
    logic [1:0]           intc_req, intc_gnt, intc_we, intc_merr;
    logic [1:0][3:0]      intc_be;
    logic [1:0][1:0]      intc_add;
    logic [1:0][31:0]     intc_wdata, intc_rdata;
    logic [1:0]           bank_req, bank_gnt, bank_we;
    logic [1:0][3:0]      bank_be;
    logic [1:0][1:0]      bank_add;
    logic [1:0][31:0]     bank_wdata;
    logic [1:0][31:0]     rd_q;
    logic [1:0]           sflag_q, mflag_q;
    logic [3:0]           single_cnt, multi_cnt;
    logic                 err_valid, err_multi, sweep_done;
    logic [0:0]           err_way;
    logic [1:0]           err_add;

    ecc_scrubber_multi_way #(
        .NumWays       (2),
        .Width         (32),
        .Depth         (4),
        .IntervalWidth (4),
        .MaxStall      (8),
        .CntWidth      (4)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .enable_i         (enable),
        .interval_i       (interval),
        .correct_en_i     (correct_en),
        .intc_req_i       (intc_req),
        .intc_gnt_o       (intc_gnt),
        .intc_we_i        (intc_we),
        .intc_be_i        (intc_be),
        .intc_add_i       (intc_add),
        .intc_wdata_i     (intc_wdata),
        .intc_rdata_o     (intc_rdata),
        .intc_multi_err_o (intc_merr),
        .bank_req_o       (bank_req),
        .bank_gnt_i       (bank_gnt),
        .bank_we_o        (bank_we),
        .bank_be_o        (bank_be),
        .bank_add_o       (bank_add),
        .bank_wdata_o     (bank_wdata),
        .bank_rdata_i     (rd_q),
        .single_err_i     (sflag_q),
        .multi_err_i      (mflag_q),
        .single_cnt_o     (single_cnt),
        .multi_cnt_o      (multi_cnt),
        .err_valid_o      (err_valid),
        .err_multi_o      (err_multi),
        .err_way_o        (err_way),
        .err_add_o        (err_add),
        .err_ack_i        (err_ack),
        .sweep_done_o     (sweep_done)
    );

    typedef struct {
        int         way;
        int         add;
        logic [31:0] wdata;
        logic [3:0]  be;
    } op_t;

    logic [31:0] init_mem [NW][D];
    logic [31:0] mem      [NW][D];
    bit          s_map    [NW][D];
    bit          m_map    [NW][D];
    op_t         rd_ops[$];
    op_t         wr_ops[$];

    int n_vec = 0;
    int n_err = 0;
    int pos   = 0;

    // Bank model: one-cycle read latency, error flags travel with the data.
    always @(posedge clk) begin
        for (int w = 0; w < NW; w++) begin
            sflag_q[w] <= 1'b0;
            mflag_q[w] <= 1'b0;
            if (rst_i) begin
                for (int a = 0; a < D; a++) mem[w][a] <= init_mem[w][a];
            end else if (bank_req[w] && bank_gnt[w]) begin
                int a;
                op_t o;
                a = int'(bank_add[w]);
                o.way = w; o.add = a; o.wdata = bank_wdata[w]; o.be = bank_be[w];
                if (bank_we[w]) begin
                    for (int b = 0; b < 4; b++)
                        if (bank_be[w][b]) mem[w][a][8*b +: 8] <= bank_wdata[w][8*b +: 8];
                    if (!intc_req[w]) wr_ops.push_back(o);
                end else begin
                    rd_q[w]    <= mem[w][a];
                    sflag_q[w] <= s_map[w][a];
                    mflag_q[w] <= m_map[w][a];
                    if (!intc_req[w]) rd_ops.push_back(o);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every scrub read must follow the sweep order from the current model position.
    task automatic check_reads(output int n);
        op_t o;
        n = 0;
        while (rd_ops.size() > 0) begin
            o = rd_ops.pop_front();
            chk("scrub_way", o.way, pos % NW);
            chk("scrub_add", o.add, (pos / NW) % D);
            pos++;
            n++;
        end
    endtask

    task automatic set_maps(input bit s, input bit m);
        for (int w = 0; w < NW; w++)
            for (int a = 0; a < D; a++) begin
                s_map[w][a] = s;
                m_map[w][a] = m;
            end
    endtask

    initial begin
        int  n, n2, found, p0, w, a, k, exp_cnt;
        op_t o;

        rst_i = 1'b1; enable = 1'b0; correct_en = 1'b0; err_ack = 1'b0; interval = '0;
        intc_req = 2'b01; intc_we = '0; intc_be = '0; intc_add = '0; intc_wdata = '0;
        bank_gnt = 2'b11;
        for (int i = 0; i < NW; i++)
            for (int j = 0; j < D; j++) init_mem[i][j] = $urandom;
        set_maps(1'b0, 1'b0);

        // Reset: passthrough of the live request, everything else cleared.
        tick(3);
        chk("rst_bank_req", bank_req, 2'b01);
        chk("rst_intc_gnt", intc_gnt, 2'b11);
        chk("rst_single_cnt", single_cnt, 0);
        chk("rst_multi_cnt", multi_cnt, 0);
        chk("rst_err_valid", err_valid, 0);
        chk("rst_sweep", sweep_done, 0);
        rst_i = 1'b0; intc_req = '0;
        tick(1);

        // Full sweep, no traffic, no errors.
        enable = 1'b1; found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk);
            if (sweep_done) found = 1;
        end
        enable = 1'b0;
        chk("sweep_seen", found, 1);
        chk("ops_before_sweep", rd_ops.size(), NW * D);
        chk("sweep_no_writes", wr_ops.size(), 0);
        check_reads(n);
        tick(1);
        chk("sweep_pulse_width", sweep_done, 0);
        chk("sweep_single_cnt", single_cnt, 0);
        chk("sweep_multi_cnt", multi_cnt, 0);
        chk("sweep_err_valid", err_valid, 0);
        tick(12);
        check_reads(n);

        // Single error at (w1,a2) with write-back enabled.
        s_map[1][2] = 1'b1; correct_en = 1'b1;
        interval = 4'($urandom_range(1, 3)); enable = 1'b1; found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            @(negedge clk);
            if (wr_ops.size() > 0) found = 1;
        end
        enable = 1'b0; s_map[1][2] = 1'b0;
        chk("wb_seen", found, 1);
        tick(12);
        check_reads(n);
        chk("wb_count", wr_ops.size(), 1);
        if (wr_ops.size() > 0) begin
            o = wr_ops.pop_front();
            chk("wb_way", o.way, 1);
            chk("wb_add", o.add, 2);
            chk("wb_data", o.wdata, init_mem[1][2]);
            chk("wb_be", o.be, 4'hf);
        end
        chk("wb_single_cnt", single_cnt, 1);
        chk("wb_err_valid", err_valid, 1);
        chk("wb_err_way", err_way, 1);
        chk("wb_err_add", err_add, 2);
        chk("wb_err_multi", err_multi, 0);

        err_ack = 1'b1;
        tick(1);
        err_ack = 1'b0;
        chk("ack1_clears", err_valid, 0);

        // Single error at a random position, write-back disabled.
        w = int'($urandom % NW); a = int'($urandom % D);
        s_map[w][a] = 1'b1; correct_en = 1'b0; interval = '0; enable = 1'b1; found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(negedge clk);
            if (single_cnt == 4'd2) found = 1;
        end
        enable = 1'b0; s_map[w][a] = 1'b0;
        chk("noc_seen", found, 1);
        tick(12);
        check_reads(n);
        chk("noc_no_write", wr_ops.size(), 0);
        chk("noc_single_cnt", single_cnt, 2);
        chk("noc_err_valid", err_valid, 1);
        chk("noc_err_way", err_way, w);
        chk("noc_err_add", err_add, a);
        chk("noc_err_multi", err_multi, 0);
        err_ack = 1'b1;
        tick(1);
        err_ack = 1'b0;
        chk("ack2_clears", err_valid, 0);

        // Interconnect holds the scrubbed way busy: forced read after 8 stalled cycles.
        w = pos % NW; a = (pos / NW) % D;
        intc_req = 2'b11; intc_be = {4'hf, 4'hf};
        intc_add[w] = 2'(a + 1); intc_add[1-w] = 2'(a);
        enable = 1'b1; k = 0;
        for (int i = 1; i <= 30 && k == 0; i++) begin
            @(negedge clk);
            if (intc_gnt[w] == 1'b0) begin
                k = i;
                chk("force_req", bank_req[w], 1);
                chk("force_add", bank_add[w], a);
                chk("force_be", bank_be[w], 0);
                chk("force_other_gnt", intc_gnt[1-w], 1);
                intc_req = '0;
                enable = 1'b0;
            end
        end
        intc_req = '0; enable = 1'b0; intc_be = '0;
        chk("force_cycle", k, 9);
        tick(12);
        check_reads(n);
        chk("force_read_count", n, 1);

        // Multi errors everywhere: record the first, then saturate the counter.
        set_maps(1'b0, 1'b1);
        p0 = pos; enable = 1'b1;
        tick(20);
        enable = 1'b0;
        tick(12);
        check_reads(n);
        exp_cnt = (n > 15) ? 15 : n;
        chk("multi_cnt_partial", multi_cnt, exp_cnt);
        chk("multi_err_valid", err_valid, 1);
        chk("multi_err_multi", err_multi, 1);
        chk("multi_err_way", err_way, p0 % NW);
        chk("multi_err_add", err_add, (p0 / NW) % D);
        enable = 1'b1;
        tick(80);
        enable = 1'b0;
        tick(12);
        check_reads(n2);
        exp_cnt = (n + n2 > 15) ? 15 : n + n2;
        chk("sat_enough_ops", (n + n2) >= 16, 1);
        chk("multi_cnt_sat", multi_cnt, exp_cnt);
        chk("sat_single_cnt", single_cnt, 2);
        chk("sat_record_kept", err_add, (p0 / NW) % D);

        // Reset in the middle of a write-back.
        set_maps(1'b1, 1'b0);
        correct_en = 1'b1; interval = '0; enable = 1'b1; found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            @(negedge clk);
            if (bank_we != 2'b00) found = 1;
        end
        chk("write_reached", found, 1);
        rst_i = 1'b1; enable = 1'b0; intc_we = 2'b10; intc_req = 2'b01;
        tick(1);
        chk("mid_rst_we", bank_we, intc_we);
        chk("mid_rst_req", bank_req, intc_req);
        chk("mid_rst_single", single_cnt, 0);
        chk("mid_rst_multi", multi_cnt, 0);
        chk("mid_rst_valid", err_valid, 0);
        chk("mid_rst_sweep", sweep_done, 0);
        rst_i = 1'b0; intc_req = '0; intc_we = '0;
        set_maps(1'b0, 1'b0);
        rd_ops.delete(); wr_ops.delete(); pos = 0;
        tick(2);
        enable = 1'b1;
        tick(20);
        enable = 1'b0;
        tick(12);
        check_reads(n);
        chk("post_rst_ops", n > 0, 1);
        chk("post_rst_no_err", single_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
